// File: rtl/rd_fifo_arbiter.sv
// rd_fifo_arbiter
// Merges byte strobes from NUM_REQ peripheral requesters into one shared
// read FIFO. Each requester has a one-deep holding register and a pending
// flag. A round-robin arbiter moves at most one held byte per cycle into a
// registered FIFO write port. It stalls while the FIFO reports almost-full.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   req_data       NUM_REQ packed DATAWIDTH-bit requester words
//   req_valid      per-requester one-cycle write strobe
//   fifo_full      almost-full from the shared FIFO; blocks new grants
//   fifo_wr_en     registered FIFO write strobe
//   fifo_wr_data   registered FIFO write data
//   grant_id       requester index of the word on fifo_wr_data
//   pending        per-requester holding-register occupied flag
//   drop_pulse     per-requester one-cycle pulse when a strobe was lost
//   drop_count     (only with ARB_DROP_COUNT_EN) saturating 16-bit total of
//                  dropped bytes
//
// Build option: define ARB_DROP_COUNT_EN to add the drop_count port.
module rd_fifo_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATAWIDTH-1:0]         fifo_wr_data,
  output logic [GW-1:0]                grant_id,
  output logic [NUM_REQ-1:0]           pending,
  output logic [NUM_REQ-1:0]           drop_pulse
`ifdef ARB_DROP_COUNT_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  logic [NUM_REQ-1:0][DATAWIDTH-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0]                pend_q, pend_d;
  logic [NUM_REQ-1:0]                drop_q, drop_d;
  logic                              wr_en_q;
  logic [DATAWIDTH-1:0]              wr_data_q;
  logic [GW-1:0]                     gid_q;
  logic [GW-1:0]                     last_q;

  logic                              gnt_vld;
  logic [GW-1:0]                     gnt_idx;
  logic [GW:0]                       scan;

  // Round-robin pick. Scan upward from last_q+1 with wrap, and take the first
  // pending slot. The extra bit on scan absorbs the carry before the wrap.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, last_q} + (GW+1)'(k);
      if (scan >= (GW+1)'(NUM_REQ)) scan = scan - (GW+1)'(NUM_REQ);
      if (!gnt_vld && !fifo_full && pend_q[GW'(scan)]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(scan);
      end
    end
  end

  // Per-lane capture/drop. The granted lane's slot is read out at this edge.
  // So it may accept a new strobe in the same cycle without losing anything.
  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    drop_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (!pend_q[i] || (gnt_vld && gnt_idx == GW'(i))) begin
          hold_d[i] = req_data[i*DATAWIDTH +: DATAWIDTH];
          pend_d[i] = 1'b1;
        end else begin
          drop_d[i] = 1'b1;
        end
      end else if (gnt_vld && gnt_idx == GW'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q    <= '0;
      pend_q    <= '0;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      gid_q     <= '0;
      last_q    <= GW'(NUM_REQ-1);  // requester 0 wins first
    end else begin
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      wr_en_q <= gnt_vld;
      if (gnt_vld) begin
        wr_data_q <= hold_q[gnt_idx];
        gid_q     <= gnt_idx;
        last_q    <= gnt_idx;
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant_id     = gid_q;
  assign pending      = pend_q;
  assign drop_pulse   = drop_q;

`ifdef ARB_DROP_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;

  // Accumulate in 17 bits so overflow is visible, then clamp at all-ones.
  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int i = 0; i < NUM_REQ; i++) cnt_sum = cnt_sum + 17'(drop_d[i]);
    cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign drop_count = cnt_q;
`endif

endmodule
